mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency backing memory between the pipeline's instruction-fetch port (read-only) and its MEM-stage data port (LW read / SW write).
- Sits between the IF/MEM stages and the unified memory.
- Arbitrates with data-port priority and bounded instruction-fetch starvation, sequences each access through a small FSM, and returns registered data with a one-cycle ack pulse per port.
- The pipeline control uses the absence of i_ack / d_ack as its stall condition.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch port and the data port.
// Data has priority unless fetch has been starved STARVE_MAX times. Read data is registered, and each port gets a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              m_valid_q, m_valid_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_elig;
  logic              d_elig;

  // A port that is being acked this cycle is masked, so its held request cannot be granted twice.
  assign i_elig = i_req & ~i_ack_q;
  assign d_elig = d_req & ~d_ack_q;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_elig && (!d_elig || streak_q == STREAK_MAX)) begin
          state_d   = BUSY_I;
          m_valid_d = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
          streak_d  = 4'd0;
        end else if (d_elig) begin
          state_d   = BUSY_D;
          m_valid_d = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
          m_wdata_d = d_wdata;
          if (!i_req) begin
            streak_d = 4'd0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end
      end
      BUSY_I: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = m_rdata;
        end
      end
      BUSY_D: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          d_ack_d   = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_valid = m_valid_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = (state_q != IDLE);

  // A requester must hold its request for the whole access it was granted.
  a_i_req_held: assert property (@(posedge clock) disable iff (!resetn)
    (state_q == BUSY_I) |-> i_req);
  a_d_req_held: assert property (@(posedge clock) disable iff (!resetn)
    (state_q == BUSY_D) |-> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic.
// A transaction-level model predicts the output of every cycle.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  logic          clock = 1'b0;
  logic          resetn;
  logic          i_req, d_req, d_we, m_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic          i_ack, d_ack, m_valid, m_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  int errors = 0;
  int checks = 0;

  // Requester queues: the head is the request currently presented to the port.
  logic [AW-1:0] i_q[$];
  dreq_t         d_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  int            lat = 0;
  int            mem_cnt = 0;
  bit            rand_mode = 0;
  bit            noise = 0;

  // Model: which port owns the memory (0 none, 1 fetch, 2 data) plus the visible results.
  int            mdl_port = 0;
  int            mdl_streak = 0;
  bit            mdl_granted = 0;
  bit            mdl_rst = 1;
  logic          mdl_iack = 0, mdl_dack = 0, mdl_we = 0;
  logic [AW-1:0] mdl_addr = '0;
  logic [DW-1:0] mdl_wdata = '0, mdl_irdata = '0, mdl_drdata = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] mem_read(logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of the model, using the inputs the DUT samples at that edge.
  task automatic model_edge();
    logic ie, de, n_iack, n_dack;
    n_iack = 1'b0;
    n_dack = 1'b0;
    mdl_granted = 0;
    if (!resetn) begin
      mdl_rst = 1; mdl_port = 0; mdl_streak = 0; mdl_we = 0;
      mdl_addr = '0; mdl_wdata = '0; mdl_irdata = '0; mdl_drdata = '0;
    end else begin
      mdl_rst = 0;
      if (mdl_port == 0) begin
        ie = i_req && !mdl_iack;
        de = d_req && !mdl_dack;
        if (ie && (!de || mdl_streak == SMAX)) begin
          mdl_port = 1; mdl_we = 0; mdl_addr = i_addr & ~32'h3;
          mdl_streak = 0; mdl_granted = 1;
        end else if (de) begin
          mdl_port = 2; mdl_we = d_we; mdl_addr = d_addr & ~32'h3;
          mdl_wdata = d_wdata; mdl_granted = 1;
          mdl_streak = i_req ? ((mdl_streak < SMAX) ? mdl_streak + 1 : SMAX) : 0;
        end
      end else if (m_ready) begin
        if (mdl_port == 1) begin
          n_iack = 1'b1; mdl_irdata = m_rdata;
        end else begin
          n_dack = 1'b1;
          if (mdl_we) mem[mdl_addr] = mdl_wdata;
          else mdl_drdata = m_rdata;
        end
        mdl_port = 0;
      end
    end
    mdl_iack = n_iack;
    mdl_dack = n_dack;
  endtask

  task automatic checkOutput();
    chk("i_ack", 32'(i_ack), 32'(mdl_iack));
    chk("d_ack", 32'(d_ack), 32'(mdl_dack));
    chk("ack_exclusive", 32'(i_ack & d_ack), 32'd0);
    chk("m_valid", 32'(m_valid), 32'(mdl_port != 0));
    chk("busy", 32'(busy), 32'(mdl_port != 0));
    chk("i_rdata", i_rdata, mdl_irdata);
    chk("d_rdata", d_rdata, mdl_drdata);
    if (mdl_port != 0 || mdl_rst) begin
      chk("m_addr", m_addr, mdl_addr);
      chk("m_we", 32'(m_we), 32'(mdl_we));
      if (mdl_we || mdl_rst) chk("m_wdata", m_wdata, mdl_wdata);
    end
  endtask

  // Present requester and memory inputs for the coming edge.
  task automatic applyStimulus();
    dreq_t r;
    if (mdl_iack && i_q.size() > 0) void'(i_q.pop_front());
    if (mdl_dack && d_q.size() > 0) void'(d_q.pop_front());
    if (rand_mode) begin
      if (i_q.size() == 0 && $urandom_range(0, 3) == 0)
        i_q.push_back(32'($urandom_range(0, 255)));
      if (d_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        r.we = 1'($urandom_range(0, 1));
        r.addr = 32'($urandom_range(0, 255));
        r.wdata = $urandom;
        d_q.push_back(r);
      end
    end
    i_req  = (i_q.size() > 0);
    i_addr = i_req ? i_q[0] : $urandom;
    d_req  = (d_q.size() > 0);
    if (d_req) begin
      d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
    end else begin
      d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
    end
    if (mdl_port != 0) begin
      if (mdl_granted) begin
        if (rand_mode) lat = $urandom_range(0, 3);
        mem_cnt = lat;
      end
      if (mem_cnt == 0) begin
        m_ready = 1'b1; m_rdata = mem_read(mdl_addr);
      end else begin
        mem_cnt--; m_ready = 1'b0; m_rdata = $urandom;
      end
    end else begin
      m_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rdata = $urandom;
    end
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus();
      @(posedge clock);
      model_edge();
      #1;
      checkOutput();
    end
  endtask

  initial begin
    dreq_t r;
    resetn = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    run(2);
    resetn = 1'b1;

    $display("[TB] single fetch");
    mem[32'h10] = 32'h8C01_0004;
    lat = 0;
    i_q.push_back(32'h10);
    run(4);
    chk("fetch_rdata", i_rdata, 32'h8C01_0004);

    $display("[TB] simultaneous requests");
    mem[32'h40] = 32'h1234_5678;
    r.we = 0; r.addr = 32'h40; r.wdata = '0;
    d_q.push_back(r);
    i_q.push_back(32'h20);
    run(6);
    chk("load_rdata", d_rdata, 32'h1234_5678);

    $display("[TB] store with slow memory");
    lat = 3;
    r.we = 1; r.addr = 32'h43; r.wdata = 32'hDEAD_BEEF;
    d_q.push_back(r);
    run(7);
    chk("store_keeps_drdata", d_rdata, 32'h1234_5678);

    $display("[TB] fetch against repeated data requests");
    lat = 0;
    i_q.push_back(32'h100);
    i_q.push_back(32'h104);
    for (int k = 0; k < 6; k++) begin
      r.we = 1'(k % 2); r.addr = 32'(8 * k + 32'h80); r.wdata = 32'(k * 32'h1111_1111);
      d_q.push_back(r);
    end
    run(24);

    $display("[TB] reset mid-access");
    lat = 6;
    r.we = 0; r.addr = 32'h88; r.wdata = '0;
    d_q.push_back(r);
    run(2);
    resetn = 1'b0;
    i_q.delete();
    d_q.delete();
    run(1);
    resetn = 1'b1;
    run(2);

    $display("[TB] ack masking with held fetch");
    lat = 0;
    for (int k = 0; k < 4; k++) i_q.push_back(32'(32'h200 + 4 * k));
    run(12);

    $display("[TB] random traffic");
    rand_mode = 1;
    noise = 1;
    run(600);
    rand_mode = 0;
    i_q.delete();
    d_q.delete();
    run(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
